sat_sweep_controller: RTL and testbench
=======================================

# sat_sweep_controller

Exhaustive-search controller for the clause evaluator.
- Holds a programmable CNF clause table and enumerates every assignment of NUM_VARS variables, one candidate per cycle.
- For each candidate it drives the evaluator's per-literal false-vector and samples the evaluator's `unsatisfied` flag.
- It stops at the first satisfying assignment, or reports UNSAT after the full sweep.
- Sits between the host configuration/control interface and a combinational clause evaluator instance.

## Interface
- NUM_CLAUSES, 16, clause table depth; must match the evaluator.
- NUM_VARS_PER_CLAUSE, 3, literal slots per clause; must match the evaluator.
- NUM_VARS, 8, number of variables swept, 1..16.
- LIT_W, $clog2(NUM_VARS)+2, literal width (derived). Literal encoding is {valid, neg, var_idx}.
- Clock and reset: one clock; reset is asynchronous and active-high.
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- cfg_we  in  1  write one clause table entry.
- cfg_addr  in  $clog2(NUM_CLAUSES)  clause index.
- cfg_en  in  1  clause enable.
- cfg_lits  in  NUM_VARS_PER_CLAUSE*LIT_W  literals; slot j is at [j*LIT_W +: LIT_W].
- start  in  1  begin a sweep.
- abort  in  1  cancel a sweep.
- busy  out  1  sweep in progress.
- done  out  1  one-cycle completion pulse.
- sat  out  1  result: a satisfying assignment was found.
- model  out  NUM_VARS  satisfying assignment; bit i is the value of x_i.
- evals  out  NUM_VARS+1  number of candidates checked.
- eval_clauses  out  NUM_CLAUSES*NUM_VARS_PER_CLAUSE  to evaluator `clauses`; 1 = literal false.
- eval_unsat  in  1  from evaluator `unsatisfied`.

## Operation
- Clause table:
  - NUM_CLAUSES entries of {en, lits}; all entries are cleared by reset.
  - cfg_we is honoured only when busy=0 and is ignored while busy.
- Literal false bit:
  - valid=1: false = (x[var_idx] == neg).
  - valid=0: false = 1, so an unused slot never satisfies its clause.
  - A clause with en=0 drives all its slots to 0, so it is never unsatisfied.
- FSM states are IDLE and RUN.
- IDLE:
  - start=1 → RUN.
  - On the same edge: eval_clauses ← f(candidate 0), tag ← 0, tag_vld ← 1, next ← 1, sat ← 0, model ← 0, evals ← 0.
- RUN, on each edge:
  - If tag_vld and eval_unsat=0: sat ← 1, model ← tag, done ← 1 → IDLE.
  - Otherwise, if next ≤ 2^NUM_VARS−1: issue next, i.e. eval_clauses ← f(next), tag ← next, next ← next+1.
  - Otherwise, once the last candidate has been checked as unsat: sat ← 0, done ← 1 → IDLE.
- evals increments on each edge where tag_vld is set in RUN, including the deciding check.
- next is NUM_VARS+1 bits wide, so the loop condition cannot wrap.
- abort in RUN:
  - → IDLE next edge; no done pulse.
  - sat, model and evals hold their pre-abort values.
  - eval_clauses ← 0.
  - abort has priority over a same-edge result.
- start while busy is ignored; abort in IDLE is ignored.
- Returning to IDLE always drives eval_clauses ← 0 and tag_vld ← 0.
- Reset at any point forces IDLE and returns all outputs to their reset values.

## Timing
- Reset values: busy 0, done 0, sat 0, model 0, evals 0, eval_clauses all 0; the clause table is all disabled.
- busy = (state == RUN), a registered output.
- Edges are numbered from start sampled at edge E0.
- Candidate k is issued at edge Ek and checked at edge E(k+1).
- A satisfying candidate k gives done high in the cycle after E(k+1), with evals = k+1.
- A full UNSAT sweep gives done after E(2^NUM_VARS), with evals = 2^NUM_VARS.
- Throughput is one candidate per cycle; eval_unsat is combinational from registered eval_clauses.
- done is a single cycle. sat, model and evals hold until the next accepted start.
- start may be asserted in the same cycle as done (state is IDLE) and is accepted.

## Configuration
- SAT_SWEEP_PERF_CNT_EN:
  - Defined: the evals counter is implemented as described.
  - Undefined: the counter logic is omitted and evals is tied to 0.
  - All other behaviour is identical in both cases.

## Test plan
- Reset check: assert rst mid-sweep → busy, done, sat, model, evals and eval_clauses are 0 immediately; a subsequent start behaves normally.
- Single clause: clause 0 = (x0 ∨ x1 ∨ x2), en=1, NUM_VARS=8, start at E0 → done after E2, sat=1, model=8'h01, evals=2.
- UNSAT sweep: clause 0 = (x0), clause 1 = (¬x0), remaining slots invalid → done after E256, sat=0, evals=256, busy high for 256 cycles.
- No clauses enabled: start → done after E1, sat=1, model=0, evals=1, eval_clauses all 0 throughout.
- Abort and ignored inputs: abort at E10 of the UNSAT case → busy=0 next cycle, no done, eval_clauses=0. A cfg_we during RUN leaves the table unchanged, verified by rerunning the single-clause case. start during RUN has no effect.
- Back-to-back: start asserted in the done cycle → a new sweep begins, and sat/model/evals clear at that edge.

Source files
------------

// File: rtl/sat_sweep_controller.sv
// rtl/sat_sweep_controller.sv - exhaustive CNF sweep controller driving a combinational clause evaluator
// Optional evals counter enabled by defining SAT_SWEEP_PERF_CNT_EN.
module sat_sweep_controller #(
    parameter int NUM_CLAUSES         = 16,
    parameter int NUM_VARS_PER_CLAUSE = 3,
    parameter int NUM_VARS            = 8,
    localparam int LIT_W              = $clog2(NUM_VARS) + 2,
    localparam int ADDR_W             = $clog2(NUM_CLAUSES)
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     cfg_we,
    input  logic [ADDR_W-1:0]                        cfg_addr,
    input  logic                                     cfg_en,
    input  logic [NUM_VARS_PER_CLAUSE*LIT_W-1:0]     cfg_lits,
    input  logic                                     start,
    input  logic                                     abort,
    output logic                                     busy,
    output logic                                     done,
    output logic                                     sat,
    output logic [NUM_VARS-1:0]                      model,
    output logic [NUM_VARS:0]                        evals,
    output logic [NUM_CLAUSES*NUM_VARS_PER_CLAUSE-1:0] eval_clauses,
    input  logic                                     eval_unsat
);

    localparam int NS = NUM_VARS_PER_CLAUSE;
    localparam int NB = NUM_CLAUSES * NUM_VARS_PER_CLAUSE;
    localparam logic [NUM_VARS:0] LAST_CAND = {1'b0, {NUM_VARS{1'b1}}};

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;

    logic                    r_en   [NUM_CLAUSES];
    logic [NS*LIT_W-1:0]     r_lits [NUM_CLAUSES];

    logic [NUM_VARS-1:0]     r_tag;
    logic                    r_tag_vld;
    logic [NUM_VARS:0]       r_next;
    logic                    r_sat;
    logic                    r_done;
    logic [NUM_VARS-1:0]     r_model;
    logic [NB-1:0]           r_eval_clauses;

    logic                    w_launch;
    logic                    w_found;
    logic                    w_issue;
    logic                    w_exhaust;
    logic                    w_leave;
    logic [NUM_VARS-1:0]     w_cand;
    logic [NB-1:0]           w_false_vec;

    // An invalid slot reads as false so it can never satisfy its clause.
    function automatic logic lit_false(input logic [LIT_W-1:0] lit,
                                       input logic [NUM_VARS-1:0] cand);
        int   idx;
        logic val;
        idx = 0;
        val = 1'b0;
        for (int b = 0; b < LIT_W - 2; b++) begin
            if (lit[b]) idx = idx + (1 << b);
        end
        for (int v = 0; v < NUM_VARS; v++) begin
            if (idx == v) val = cand[v];
        end
        if (!lit[LIT_W-1]) lit_false = 1'b1;
        else               lit_false = (val == lit[LIT_W-2]);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_launch    = 1'b0;
        w_found     = 1'b0;
        w_issue     = 1'b0;
        w_exhaust   = 1'b0;
        w_leave     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_launch    = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (abort) begin
                    w_leave = 1'b1;
                end else if (r_tag_vld && !eval_unsat) begin
                    w_found = 1'b1;
                    w_leave = 1'b1;
                end else if (r_next <= LAST_CAND) begin
                    w_issue = 1'b1;
                end else begin
                    w_exhaust = 1'b1;
                    w_leave   = 1'b1;
                end
                if (w_leave) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // A single evaluator serves both the launch (candidate 0) and the running sweep.
    assign w_cand = w_launch ? '0 : r_next[NUM_VARS-1:0];

    always_comb begin
        w_false_vec = '0;
        for (int c = 0; c < NUM_CLAUSES; c++) begin
            for (int j = 0; j < NS; j++) begin
                if (r_en[c]) w_false_vec[c*NS + j] = lit_false(r_lits[c][j*LIT_W +: LIT_W], w_cand);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < NUM_CLAUSES; c++) begin
                r_en[c]   <= 1'b0;
                r_lits[c] <= '0;
            end
            r_tag          <= '0;
            r_tag_vld      <= 1'b0;
            r_next         <= '0;
            r_sat          <= 1'b0;
            r_done         <= 1'b0;
            r_model        <= '0;
            r_eval_clauses <= '0;
        end else begin
            r_done <= 1'b0;
            if (cfg_we && r_state == S_IDLE && int'(cfg_addr) < NUM_CLAUSES) begin
                r_en[cfg_addr]   <= cfg_en;
                r_lits[cfg_addr] <= cfg_lits;
            end
            if (w_launch) begin
                r_eval_clauses <= w_false_vec;
                r_tag          <= '0;
                r_tag_vld      <= 1'b1;
                r_next         <= {{NUM_VARS{1'b0}}, 1'b1};
                r_sat          <= 1'b0;
                r_model        <= '0;
            end
            if (w_issue) begin
                r_eval_clauses <= w_false_vec;
                r_tag          <= r_next[NUM_VARS-1:0];
                r_next         <= r_next + 1'b1;
            end
            if (w_found) begin
                r_sat   <= 1'b1;
                r_model <= r_tag;
                r_done  <= 1'b1;
            end
            if (w_exhaust) begin
                r_sat  <= 1'b0;
                r_done <= 1'b1;
            end
            if (w_leave) begin
                r_eval_clauses <= '0;
                r_tag_vld      <= 1'b0;
            end
        end
    end

`ifdef SAT_SWEEP_PERF_CNT_EN
    logic              w_check;
    logic [NUM_VARS:0] r_evals;

    // Abort suppresses the count so evals holds its pre-abort value.
    assign w_check = (r_state == S_RUN) && !abort && r_tag_vld;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)           r_evals <= '0;
        else if (w_launch) r_evals <= '0;
        else if (w_check)  r_evals <= r_evals + 1'b1;
    end

    assign evals = r_evals;
`else
    assign evals = '0;
`endif

    assign busy         = (r_state == S_RUN);
    assign done         = r_done;
    assign sat          = r_sat;
    assign model        = r_model;
    assign eval_clauses = r_eval_clauses;

endmodule

// File: tb/tb_sat_sweep_controller.sv
// tb/tb_sat_sweep_controller.sv - directed bench with a clause-level reference model for sat_sweep_controller
module tb_sat_sweep_controller;

    localparam int NC  = 16;
    localparam int NS  = 3;
    localparam int NV  = 8;
    localparam int LW  = 5;
    localparam int NCAND = 1 << NV;
`ifdef SAT_SWEEP_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cfg_we = 1'b0;
    logic [3:0]        cfg_addr = '0;
    logic              cfg_en = 1'b0;
    logic [NS*LW-1:0]  cfg_lits = '0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic              busy, done, sat;
    logic [NV-1:0]     model;
    logic [NV:0]       evals;
    logic [NC*NS-1:0]  eval_clauses;
    logic              eval_unsat;

    int n_checks = 0;
    int n_fail   = 0;

    sat_sweep_controller #(.NUM_CLAUSES(NC), .NUM_VARS_PER_CLAUSE(NS), .NUM_VARS(NV)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_en(cfg_en),
        .cfg_lits(cfg_lits), .start(start), .abort(abort), .busy(busy), .done(done),
        .sat(sat), .model(model), .evals(evals), .eval_clauses(eval_clauses),
        .eval_unsat(eval_unsat)
    );

    always #5 clk = ~clk;

    // Clause evaluator: a clause is unsatisfied when all of its literal-false bits are set.
    always_comb begin
        eval_unsat = 1'b0;
        for (int c = 0; c < NC; c++) begin
            if (&eval_clauses[c*NS +: NS]) eval_unsat = 1'b1;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] ev(input int n);
        return PERF ? 64'(n) : 64'd0;
    endfunction

    // Reference model state
    logic            m_en   [NC];
    logic [NS*LW-1:0] m_lits [NC];
    logic            m_run   = 1'b0;
    logic            m_done  = 1'b0;
    logic            m_sat   = 1'b0;
    logic [NV-1:0]   m_model = '0;
    logic [NV:0]     m_evals = '0;
    logic [NC*NS-1:0] m_ec   = '0;
    int              m_e     = 0;
    bit              m_found = 1'b0;
    int              m_first = 0;

    function automatic bit lit_true(input logic [LW-1:0] lit, input int x);
        return lit[4] && (((x >> lit[2:0]) & 1) != int'(lit[3]));
    endfunction

    function automatic bit formula_sat(input int x);
        for (int c = 0; c < NC; c++) begin
            if (m_en[c]) begin
                bit ok = 1'b0;
                for (int j = 0; j < NS; j++) if (lit_true(m_lits[c][j*LW +: LW], x)) ok = 1'b1;
                if (!ok) return 1'b0;
            end
        end
        return 1'b1;
    endfunction

    function automatic logic [NC*NS-1:0] false_bits(input int x);
        logic [NC*NS-1:0] v = '0;
        for (int c = 0; c < NC; c++)
            for (int j = 0; j < NS; j++)
                v[c*NS + j] = m_en[c] && !lit_true(m_lits[c][j*LW +: LW], x);
        return v;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < NC; c++) begin m_en[c] = 1'b0; m_lits[c] = '0; end
            m_run = 0; m_done = 0; m_sat = 0; m_model = '0; m_evals = '0; m_ec = '0;
        end else begin
            m_done = 1'b0;
            if (!m_run) begin
                if (cfg_we) begin m_en[cfg_addr] = cfg_en; m_lits[cfg_addr] = cfg_lits; end
                if (start) begin
                    m_run = 1; m_e = 0; m_sat = 0; m_model = '0; m_evals = '0;
                    m_ec = false_bits(0);
                    m_found = 1'b0;
                    for (int x = NCAND - 1; x >= 0; x--) if (formula_sat(x)) begin m_found = 1'b1; m_first = x; end
                end
            end else if (abort) begin
                m_run = 0; m_ec = '0;
            end else begin
                m_e++;
                m_evals = (NV+1)'(m_e);
                if (m_found && m_e == m_first + 1) begin
                    m_sat = 1; m_model = NV'(m_first); m_done = 1; m_run = 0; m_ec = '0;
                end else if (!m_found && m_e == NCAND) begin
                    m_sat = 0; m_done = 1; m_run = 0; m_ec = '0;
                end else begin
                    m_ec = false_bits(m_e);
                end
            end
        end
    end

    always @(negedge clk) begin
        check("busy", 64'(busy), 64'(m_run));
        check("done", 64'(done), 64'(m_done));
        check("sat", 64'(sat), 64'(m_sat));
        check("model", 64'(model), 64'(m_model));
        check("evals", 64'(evals), PERF ? 64'(m_evals) : 64'd0);
        check("eval_clauses", 64'(eval_clauses), 64'(m_ec));
    end

    task automatic write_clause(input int addr, input logic en, input logic [NS*LW-1:0] lits);
        cfg_we = 1'b1; cfg_addr = 4'(addr); cfg_en = en; cfg_lits = lits;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    // Starts at a negedge; returns at the negedge where done is seen (c counts negedges after E0).
    task automatic run_sweep(input string name, output int done_c, output int busy_cnt);
        done_c = -1;
        busy_cnt = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({name, "_start_sat"}, 64'(sat), 64'd0);
        check({name, "_start_evals"}, 64'(evals), 64'd0);
        for (int c = 0; c < 600; c++) begin
            if (busy) busy_cnt++;
            if (done) begin done_c = c; break; end
            @(negedge clk);
        end
        if (done_c < 0) begin
            n_checks++; n_fail++;
            $display("FAIL %s_timeout: no done within 600 cycles", name);
        end
    endtask

    localparam logic [NS*LW-1:0] L_OR3  = {5'b10010, 5'b10001, 5'b10000};
    localparam logic [NS*LW-1:0] L_X0   = {5'b00000, 5'b00000, 5'b10000};
    localparam logic [NS*LW-1:0] L_NX0  = {5'b00000, 5'b00000, 5'b11000};
    localparam logic [NS*LW-1:0] L_X1   = {5'b00000, 5'b00000, 5'b10001};

    initial begin
        int dc, bc;
        @(negedge clk);
        @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_ec", 64'(eval_clauses), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        write_clause(0, 1'b1, L_OR3);
        run_sweep("single", dc, bc);
        check("single_done_cycle", 64'(dc), 64'd2);
        check("single_sat", 64'(sat), 64'd1);
        check("single_model", 64'(model), 64'h01);
        check("single_evals", 64'(evals), ev(2));

        run_sweep("b2b", dc, bc);
        check("b2b_done_cycle", 64'(dc), 64'd2);
        check("b2b_model", 64'(model), 64'h01);
        @(negedge clk);

        write_clause(0, 1'b1, L_X0);
        write_clause(1, 1'b1, L_NX0);
        run_sweep("unsat", dc, bc);
        check("unsat_done_cycle", 64'(dc), 64'd256);
        check("unsat_busy_cycles", 64'(bc), 64'd256);
        check("unsat_sat", 64'(sat), 64'd0);
        check("unsat_evals", 64'(evals), ev(256));
        @(negedge clk);

        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 10; c++) begin
            cfg_we = (c == 3); cfg_addr = 4'd0; cfg_en = 1'b1; cfg_lits = L_X1;
            start  = (c == 5);
            abort  = (c == 9);
            @(negedge clk);
        end
        cfg_we = 1'b0; start = 1'b0; abort = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_ec", 64'(eval_clauses), 64'd0);
        check("abort_evals", 64'(evals), ev(9));
        repeat (3) @(negedge clk);

        write_clause(1, 1'b0, L_NX0);
        run_sweep("rerun", dc, bc);
        check("rerun_done_cycle", 64'(dc), 64'd2);
        check("rerun_model", 64'(model), 64'h01);
        check("rerun_evals", 64'(evals), ev(2));
        @(negedge clk);

        write_clause(0, 1'b0, L_X0);
        run_sweep("empty", dc, bc);
        check("empty_done_cycle", 64'(dc), 64'd1);
        check("empty_sat", 64'(sat), 64'd1);
        check("empty_model", 64'(model), 64'h00);
        check("empty_evals", 64'(evals), ev(1));
        @(negedge clk);

        write_clause(0, 1'b1, L_X0);
        write_clause(1, 1'b1, L_NX0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_sat", 64'(sat), 64'd0);
        check("midrst_model", 64'(model), 64'd0);
        check("midrst_evals", 64'(evals), 64'd0);
        check("midrst_ec", 64'(eval_clauses), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_sweep("post_rst", dc, bc);
        check("post_rst_done_cycle", 64'(dc), 64'd1);
        check("post_rst_sat", 64'(sat), 64'd1);
        check("post_rst_model", 64'(model), 64'h00);
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
